xy_scan_counter: RTL and testbench
==================================

// Module: xy_scan_counter
// PURPOSE
//   Parametrised 2-D coordinate generator for VGA frame-buffer drawing (fill, clear, box).
//   Scans a run-time rectangle [x_min..x_max] x [y_min..y_max] as an inner and an outer axis counter.
//   Emits one coordinate per accepted beat over a valid/ready handshake to the plot stage.
//   Run-time scan order; per-line and per-frame completion pulses; abort.
// PARAMETERS
//   XW  8  x coordinate width (default covers 160 columns)
//   YW  7  y coordinate width (default covers 120 rows)
// PORTS
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   start      in   1   begin a scan; sampled in IDLE only
//   abort      in   1   cancel scan; any state -> IDLE
//   mode       in   2   0 row-major, 1 column-major, 2 serpentine, 3 reserved (= row-major)
//   x_min/x_max in  XW  x bounds, inclusive
//   y_min/y_max in  YW  y bounds, inclusive
//   ready      in   1   plot stage accepts current coordinate
//   x          out  XW  current x coordinate
//   y          out  YW  current y coordinate
//   valid      out  1   x/y hold a coordinate not yet accepted
//   busy       out  1   state is RUN
//   line_done  out  1   one-cycle pulse: last beat of an inner line accepted
//   done       out  1   one-cycle pulse: scan completed (not raised on abort)
// BEHAVIOUR
//   Reset: x=0, y=0, valid=0, busy=0, line_done=0, done=0, state IDLE.
//   FSM IDLE -> RUN -> FIN -> IDLE.
//   IDLE: start=1 latches bounds and mode; next cycle RUN, valid=1, x=x_min, y=y_min.
//   Start-to-first-valid latency is 1 cycle. Later bound/mode input changes are ignored.
//   Degenerate bounds: x_min>x_max or y_min>y_max -> IDLE goes to FIN directly.
//     done pulses, and no valid beat is ever issued.
//   RUN: advance only on valid&&ready. valid&&!ready holds x/y stable.
//     valid stays 1 between beats (zero-bubble: one beat per cycle while ready=1).
//   Row-major: x is the inner axis. Column-major: y is the inner axis.
//   Inner axis at its max on an accepted beat: inner reloads min, outer +1,
//     line_done=1 for the next cycle.
//   Last beat accepted (inner and outer both at max): next cycle FIN.
//     In FIN: valid=0, busy=0, done=1, line_done=1.
//     Following cycle: IDLE, all pulses 0.
//   start while busy or in FIN: ignored.
//   abort: highest priority (over start and ready).
//     Next cycle IDLE, valid=0, no done. x/y keep their last values.
//   min==max on an axis: that axis has a single position. Beat count = (Δx+1)*(Δy+1).
//   Arithmetic: unsigned, counter widths XW/YW. x_max=2^XW-1 must terminate with no wrap to 0.
//   ready is ignored when valid=0.
// CONFIGURATION
//   XY_SCAN_SERPENTINE_EN defined:
//     mode=2 reverses the inner direction on every odd line (line index relative to outer min).
//     Odd lines run inner max -> min; line_done fires when the inner axis reaches min.
//   XY_SCAN_SERPENTINE_EN undefined:
//     no reverse logic is synthesised; mode=2 behaves as mode=0.
// STRUCTURE
//   Package xy_scan_pkg:
//     typedef enum {IDLE, RUN, FIN} scan_state_t
//     typedef enum logic [1:0] {ROW, COL, SERP, RSVD} scan_mode_t
//   Sub-module axis_counter #(W): one instance per axis.
//     Inputs: load-to-min, load-to-max, step (with up/down direction), min, max.
//     Output: at_end flag (max when counting up, min when counting down).
//   Top level: FSM, axis-role muxing by mode, handshake, pulse registers.
// TESTING
//   1. Reset mid-RUN (reset=0 for 1 cycle): all outputs 0 asynchronously; IDLE on release.
//   2. mode0, x 2..4, y 5..6, ready=1:
//      6 beats (2,5)(3,5)(4,5)(2,6)(3,6)(4,6).
//      line_done after beat 3 and beat 6; done the cycle after beat 6.
//   3. mode1, same bounds: (2,5)(2,6)(3,5)(3,6)(4,5)(4,6).
//   4. mode0, x 0..1, y 0..0, ready toggling 1,0,0,1:
//      x/y held during ready=0; exactly 2 beats; done once.
//   5. Abort after 3 beats of a 4x4 scan: valid=0 next cycle, done never pulses.
//      A new start is accepted 1 cycle later.
//   6. x_min=9, x_max=3: done pulses the cycle after start with zero valid beats.
//      Serpentine (macro on), x 0..2, y 0..1:
//      (0,0)(1,0)(2,0)(2,1)(1,1)(0,1).

Source files
------------

// File: rtl/xy_scan_pkg.sv
// Shared types for the 2-D scan coordinate generator.
// Scan states and run-time scan-order encoding.
package xy_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } scan_state_t;

  typedef enum logic [1:0] {
    ROW,
    COL,
    SERP,
    RSVD
  } scan_mode_t;

endpackage

// File: rtl/xy_scan_counter_if.sv
// Control, bounds and coordinate handshake bundle between a drawing controller
// and xy_scan_counter. The counter uses the master modport.
interface xy_scan_counter_if
  import xy_scan_pkg::*;
#(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7
) ();

  logic          start;
  logic          abort;
  scan_mode_t    mode;
  logic [XW-1:0] x_min;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_min;
  logic [YW-1:0] y_max;
  logic          ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          valid;
  logic          busy;
  logic          line_done;
  logic          done;

  modport master (
    input  start, abort, mode, x_min, x_max, y_min, y_max, ready,
    output x, y, valid, busy, line_done, done
  );

  modport slave (
    output start, abort, mode, x_min, x_max, y_min, y_max, ready,
    input  x, y, valid, busy, line_done, done
  );

endinterface

// File: rtl/xy_scan_counter_axis.sv
// Single-axis up/down counter between run-time bounds; at_end flags the bound
// in the current counting direction (max when up, min when down).
module axis_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_min,
  input  logic         load_max,
  input  logic         step,
  input  logic         up,
  input  logic [W-1:0] min,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         at_end
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_min) begin
      value_d = min;
    end else if (load_max) begin
      value_d = max;
    end else if (step) begin
      value_d = up ? value_q + 1'b1 : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign at_end = up ? (value_q == max) : (value_q == min);

endmodule

// File: rtl/xy_scan_counter.sv
// 2-D rectangle scan generator: one coordinate per accepted valid/ready beat.
// Define XY_SCAN_SERPENTINE_EN to make mode SERP reverse the inner axis on odd lines.
module xy_scan_counter
  import xy_scan_pkg::*;
#(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7
) (
  input logic               clk,
  input logic               reset,
  xy_scan_counter_if.master bus
);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] x_min_q, x_max_q, x_lo, x_hi, x_val;
  logic [YW-1:0] y_min_q, y_max_q, y_lo, y_hi, y_val;
  logic          col_q;
  logic          line_q, line_d;

  logic go, degen, accept;
  logic x_end, y_end, inner_end, outer_end, wrap, last;
  logic inner_step, outer_step, reload_min, reload_max, inner_up;
  logic x_load_min, x_load_max, x_step, x_up;
  logic y_load_min, y_load_max, y_step, y_up;

  assign go     = (state_q == IDLE) && bus.start && !bus.abort;
  assign degen  = (bus.x_min > bus.x_max) || (bus.y_min > bus.y_max);
  assign accept = (state_q == RUN) && bus.ready && !bus.abort;

  assign inner_end  = col_q ? y_end : x_end;
  assign outer_end  = col_q ? x_end : y_end;
  assign wrap       = accept && inner_end;
  assign last       = wrap && outer_end;
  assign inner_step = accept && !inner_end;
  assign outer_step = wrap && !last;

`ifdef XY_SCAN_SERPENTINE_EN
  logic serp_q, odd_q;

  // Entering an odd line starts the inner axis at max and counts down.
  assign reload_max = outer_step && serp_q && !odd_q;
  assign inner_up   = !(serp_q && odd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serp_q <= 1'b0;
      odd_q  <= 1'b0;
    end else if (go) begin
      serp_q <= (bus.mode == SERP);
      odd_q  <= 1'b0;
    end else if (outer_step) begin
      odd_q  <= !odd_q;
    end
  end
`else
  assign reload_max = 1'b0;
  assign inner_up   = 1'b1;
`endif

  assign reload_min = outer_step && !reload_max;

  // Bounds come straight from the bus on the start cycle, from the latches afterwards.
  assign x_lo = (state_q == IDLE) ? bus.x_min : x_min_q;
  assign x_hi = (state_q == IDLE) ? bus.x_max : x_max_q;
  assign y_lo = (state_q == IDLE) ? bus.y_min : y_min_q;
  assign y_hi = (state_q == IDLE) ? bus.y_max : y_max_q;

  assign x_load_min = (go && !degen) || (!col_q && reload_min);
  assign x_load_max = !col_q && reload_max;
  assign x_step     = col_q ? outer_step : inner_step;
  assign x_up       = col_q || inner_up;

  assign y_load_min = (go && !degen) || (col_q && reload_min);
  assign y_load_max = col_q && reload_max;
  assign y_step     = col_q ? inner_step : outer_step;
  assign y_up       = !col_q || inner_up;

  axis_counter #(
    .W (XW)
  ) u_x_axis (
    .clk      (clk),
    .reset    (reset),
    .load_min (x_load_min),
    .load_max (x_load_max),
    .step     (x_step),
    .up       (x_up),
    .min      (x_lo),
    .max      (x_hi),
    .value    (x_val),
    .at_end   (x_end)
  );

  axis_counter #(
    .W (YW)
  ) u_y_axis (
    .clk      (clk),
    .reset    (reset),
    .load_min (y_load_min),
    .load_max (y_load_max),
    .step     (y_step),
    .up       (y_up),
    .min      (y_lo),
    .max      (y_hi),
    .value    (y_val),
    .at_end   (y_end)
  );

  always_comb begin
    state_d = state_q;
    line_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = degen ? FIN : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = FIN;
        end else begin
          line_d = wrap;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      line_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      col_q   <= 1'b0;
    end else if (go) begin
      x_min_q <= bus.x_min;
      x_max_q <= bus.x_max;
      y_min_q <= bus.y_min;
      y_max_q <= bus.y_max;
      col_q   <= (bus.mode == COL);
    end
  end

  assign bus.x         = x_val;
  assign bus.y         = y_val;
  assign bus.valid     = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == FIN);
  assign bus.line_done = line_q || (state_q == FIN);

endmodule

// File: tb/tb_xy_scan_counter.sv
// Bench for xy_scan_counter: a transaction-level model (precomputed coordinate
// list per scan) checked every cycle, plus directed literal expectations.
module tb_xy_scan_counter;
  import xy_scan_pkg::*;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
`ifdef XY_SCAN_SERPENTINE_EN
  localparam bit SerpOn = 1'b1;
`else
  localparam bit SerpOn = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    bit le;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  xy_scan_counter_if #(.XW(XW), .YW(YW)) bus ();

  xy_scan_counter #(.XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  beat_t m_q[$];
  bit    m_run = 0, m_fin = 0, m_line = 0;
  int    m_x = 0, m_y = 0;

  // Observation logs
  int acc_x[$], acc_y[$], acc_cyc[$], ld_cyc[$], done_cyc[$];
  int cyc = 0, first_valid = -1, st_cyc = 0;
  bit chk_en = 0;
  logic          prev_valid = 1'b0;
  logic [XW-1:0] prev_x = '0;
  logic [YW-1:0] prev_y = '0;

  task automatic build_list(input int xl, input int xh, input int yl, input int yh,
                            input scan_mode_t md);
    bit col;
    bit serp;
    int il, ih, ol, oh;
    col  = (md == COL);
    serp = SerpOn && (md == SERP);
    il = col ? yl : xl;
    ih = col ? yh : xh;
    ol = col ? xl : yl;
    oh = col ? xh : yh;
    m_q.delete();
    if (xl > xh || yl > yh) return;
    for (int o = ol; o <= oh; o++) begin
      for (int k = 0; k <= ih - il; k++) begin
        beat_t b;
        int i;
        i = (serp && ((o - ol) % 2 == 1)) ? ih - k : il + k;
        b.le = (k == ih - il);
        b.x  = col ? o : i;
        b.y  = col ? i : o;
        m_q.push_back(b);
      end
    end
  endtask

  task automatic model_step();
    beat_t b;
    m_line = 0;
    if (bus.abort) begin
      m_run = 0;
      m_fin = 0;
      m_q.delete();
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        build_list(int'(bus.x_min), int'(bus.x_max), int'(bus.y_min), int'(bus.y_max),
                   bus.mode);
        if (m_q.size() == 0) begin
          m_fin = 1;
        end else begin
          m_run = 1;
          m_x = m_q[0].x;
          m_y = m_q[0].y;
        end
      end
    end else if (bus.ready) begin
      b = m_q.pop_front();
      if (m_q.size() == 0) begin
        m_run = 0;
        m_fin = 1;
      end else begin
        m_line = b.le;
        m_x = m_q[0].x;
        m_y = m_q[0].y;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_run = 0; m_fin = 0; m_line = 0; m_x = 0; m_y = 0;
        m_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle compare; inputs change 1 time unit after negedge, so at negedge they
  // still hold what the preceding posedge sampled.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        if (prev_valid && bus.ready && !bus.abort && reset) begin
          acc_x.push_back(int'(prev_x));
          acc_y.push_back(int'(prev_y));
          acc_cyc.push_back(cyc);
        end
        if (bus.line_done === 1'b1) ld_cyc.push_back(cyc);
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
        if (bus.valid === 1'b1 && first_valid < 0) first_valid = cyc;
        checks++;
        if (bus.valid !== m_run || bus.busy !== m_run || bus.line_done !== (m_line || m_fin) ||
            bus.done !== m_fin || bus.x !== XW'(m_x) || bus.y !== YW'(m_y)) begin
          errors++;
          $display("FAIL cycle %0d model: dut v=%b b=%b ld=%b d=%b x=%0d y=%0d, want v=%b b=%b ld=%b d=%b x=%0d y=%0d",
                   cyc, bus.valid, bus.busy, bus.line_done, bus.done, bus.x, bus.y,
                   m_run, m_run, m_line || m_fin, m_fin, m_x, m_y);
        end
      end
      prev_valid = bus.valid;
      prev_x = bus.x;
      prev_y = bus.y;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_beats(input string tag, input int ex[], input int ey[]);
    check({tag, " beat count"}, acc_x.size(), ex.size());
    for (int i = 0; i < ex.size() && i < acc_x.size(); i++) begin
      check($sformatf("%s beat%0d x", tag, i), acc_x[i], ex[i]);
      check($sformatf("%s beat%0d y", tag, i), acc_y[i], ey[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_x.delete(); acc_y.delete(); acc_cyc.delete();
    ld_cyc.delete(); done_cyc.delete();
    first_valid = -1;
  endtask

  task automatic start_scan(input int xl, input int xh, input int yl, input int yh,
                            input scan_mode_t md);
    bus.x_min = XW'(xl);
    bus.x_max = XW'(xh);
    bus.y_min = YW'(yl);
    bus.y_max = YW'(yh);
    bus.mode  = md;
    bus.start = 1'b1;
    st_cyc    = cyc;
    tick();
    bus.start = 1'b0;
    // Bound inputs are scrambled to confirm they were latched.
    bus.x_min = 8'd77; bus.x_max = 8'd1; bus.y_min = 7'd50; bus.y_max = 7'd3;
    bus.mode  = COL;
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.ready = 0; bus.mode = ROW;
    bus.x_min = 0; bus.x_max = 0; bus.y_min = 0; bus.y_max = 0;
    #1;
    check("reset valid", int'(bus.valid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset x", int'(bus.x), 0);
    check("reset done", int'(bus.done), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_en = 1;

    // Reset asserted mid-RUN clears outputs asynchronously.
    bus.ready = 1;
    start_scan(1, 3, 1, 3, ROW);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("async rst valid", int'(bus.valid), 0);
    check("async rst busy", int'(bus.busy), 0);
    check("async rst x", int'(bus.x), 0);
    check("async rst y", int'(bus.y), 0);
    check("async rst line_done", int'(bus.line_done), 0);
    check("async rst done", int'(bus.done), 0);
    tick();
    reset = 1'b1;
    tick();
    check("post rst busy", int'(bus.busy), 0);

    // Row-major 3x2.
    clear_logs();
    bus.ready = 1;
    start_scan(2, 4, 5, 6, ROW);
    repeat (8) tick();
    check_beats("row", '{2, 3, 4, 2, 3, 4}, '{5, 5, 5, 6, 6, 6});
    check("row latency", first_valid - st_cyc, 1);
    check("row line_done count", ld_cyc.size(), 2);
    check("row done count", done_cyc.size(), 1);
    if (ld_cyc.size() == 2 && acc_cyc.size() == 6 && done_cyc.size() == 1) begin
      check("row line_done after beat3", ld_cyc[0], acc_cyc[2]);
      check("row line_done after beat6", ld_cyc[1], acc_cyc[5]);
      check("row done after beat6", done_cyc[0], acc_cyc[5]);
    end

    // Column-major, same bounds.
    clear_logs();
    start_scan(2, 4, 5, 6, COL);
    repeat (8) tick();
    check_beats("col", '{2, 2, 3, 3, 4, 4}, '{5, 6, 5, 6, 5, 6});
    check("col done count", done_cyc.size(), 1);

    // Backpressure: ready 1,0,0,1.
    clear_logs();
    start_scan(0, 1, 0, 0, ROW);
    bus.ready = 1; tick();
    bus.ready = 0; tick(); tick();
    bus.ready = 1;
    repeat (4) tick();
    check_beats("bp", '{0, 1}, '{0, 0});
    check("bp done count", done_cyc.size(), 1);
    if (acc_cyc.size() == 2) check("bp beat gap", acc_cyc[1] - acc_cyc[0], 3);

    // Abort after 3 beats of a 4x4 scan, then immediate restart.
    clear_logs();
    start_scan(0, 3, 0, 3, ROW);
    tick(); tick(); tick();
    bus.abort = 1;
    tick();
    bus.abort = 0;
    check("abort valid", int'(bus.valid), 0);
    check("abort x kept", int'(bus.x), 3);
    check("abort y kept", int'(bus.y), 0);
    check("abort beats", acc_x.size(), 3);
    check("abort no done", done_cyc.size(), 0);
    start_scan(5, 5, 1, 1, ROW);
    check("restart valid", int'(bus.valid), 1);
    check("restart x", int'(bus.x), 5);
    repeat (3) tick();

    // Degenerate bounds.
    clear_logs();
    start_scan(9, 3, 0, 0, ROW);
    repeat (3) tick();
    check("degen beats", acc_x.size(), 0);
    check("degen no valid", first_valid, -1);
    check("degen done count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("degen done latency", done_cyc[0] - st_cyc, 1);

    // Mode 2: serpentine when enabled, otherwise row-major.
    clear_logs();
    start_scan(0, 2, 0, 1, SERP);
    repeat (8) tick();
`ifdef XY_SCAN_SERPENTINE_EN
    check_beats("serp", '{0, 1, 2, 2, 1, 0}, '{0, 0, 0, 1, 1, 1});
`else
    check_beats("serp", '{0, 1, 2, 0, 1, 2}, '{0, 0, 0, 1, 1, 1});
`endif
    check("serp line_done count", ld_cyc.size(), 2);

    // Top-of-range bounds must stop without wrapping; reserved mode acts as row-major.
    clear_logs();
    start_scan(254, 255, 126, 127, RSVD);
    repeat (7) tick();
    check_beats("edge", '{254, 255, 254, 255}, '{126, 126, 127, 127});
    check("edge done count", done_cyc.size(), 1);
    check("edge idle", int'(bus.busy), 0);

    chk_en = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
